// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller with IR, BYPASS/IDCODE/CHAIN_SEL DRs and boundary-scan sequencing
//   tck         test clock, all state changes on its rising edge
//   trst        asynchronous active-high reset
//   tms, tdi    test mode select and serial data in
//   bsr_so      serial out of the selected boundary-scan chain
//   tdo, tdo_en serial data out and its enable (Shift-IR/Shift-DR only)
//   chain_sel   select to the downstream scan-chain mux
//   bsr_*       capture/shift/update strobes, EXTEST mode and serial in to the chains
//   tap_state   current FSM state for debug
module jtag_tap_ctrl #(
    parameter int          CHAIN_NUM  = 2,
    parameter int          SEL_WIDTH  = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1,
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h4A7B_2001
) (
    input  logic                 tck,
    input  logic                 trst,
    input  logic                 tms,
    input  logic                 tdi,
    input  logic                 bsr_so,
    output logic                 tdo,
    output logic                 tdo_en,
    output logic [SEL_WIDTH-1:0] chain_sel,
    output logic                 bsr_capture,
    output logic                 bsr_shift,
    output logic                 bsr_update,
    output logic                 bsr_mode,
    output logic                 bsr_tdi,
    output logic [3:0]           tap_state
);
    typedef enum logic [3:0] {
        TLR = 4'd0, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } state_e;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_CSEL   = IR_WIDTH'(3);

    state_e                state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [31:0]           id_sr_q, id_sr_d;
    logic [SEL_WIDTH-1:0]  csel_sr_q, csel_sr_d, chain_sel_q, chain_sel_d;
    logic                  bypass_q, bypass_d;
    logic                  is_bsr, is_idcode, is_csel, is_bypass;

    assign is_bsr    = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
    assign is_idcode = ir_q == IR_IDCODE;
    assign is_csel   = ir_q == IR_CSEL;
    assign is_bypass = !(is_bsr || is_idcode || is_csel);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
        endcase
    end

    // Entering TLR by TMS restores the same register state as trst.
    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        id_sr_d     = id_sr_q;
        csel_sr_d   = csel_sr_q;
        chain_sel_d = chain_sel_q;
        bypass_d    = bypass_q;
        if (state_d == TLR) begin
            ir_d        = IR_IDCODE;
            ir_sr_d     = '0;
            id_sr_d     = '0;
            csel_sr_d   = '0;
            chain_sel_d = '0;
            bypass_d    = 1'b0;
        end else if (state_q == CAP_IR) begin
            ir_sr_d = IR_WIDTH'(1);
        end else if (state_q == SH_IR) begin
            ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
        end else if (state_q == UPD_IR) begin
            ir_d = ir_sr_q;
        end else if (state_q == CAP_DR) begin
            id_sr_d   = is_idcode ? IDCODE_VAL  : id_sr_q;
            csel_sr_d = is_csel   ? chain_sel_q : csel_sr_q;
            bypass_d  = is_bypass ? 1'b0        : bypass_q;
        end else if (state_q == SH_DR) begin
            id_sr_d   = is_idcode ? {tdi, id_sr_q[31:1]} : id_sr_q;
            // Concatenate-and-shift keeps this valid for a 1-bit select register.
            csel_sr_d = is_csel   ? SEL_WIDTH'({tdi, csel_sr_q} >> 1) : csel_sr_q;
            bypass_d  = is_bypass ? tdi : bypass_q;
        end else if (state_q == UPD_DR && is_csel && 32'(csel_sr_q) < 32'(CHAIN_NUM)) begin
            chain_sel_d = csel_sr_q;
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q     <= TLR;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            id_sr_q     <= '0;
            csel_sr_q   <= '0;
            chain_sel_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            id_sr_q     <= id_sr_d;
            csel_sr_q   <= csel_sr_d;
            chain_sel_q <= chain_sel_d;
            bypass_q    <= bypass_d;
        end
    end

    assign tdo_en      = (state_q == SH_IR) || (state_q == SH_DR);
    assign tdo         = (state_q == SH_IR) ? ir_sr_q[0] :
                         (state_q != SH_DR) ? 1'b0 :
                         is_bsr    ? bsr_so :
                         is_idcode ? id_sr_q[0] :
                         is_csel   ? csel_sr_q[0] : bypass_q;
    assign bsr_capture = is_bsr && (state_q == CAP_DR);
    assign bsr_shift   = is_bsr && (state_q == SH_DR);
    assign bsr_update  = is_bsr && (state_q == UPD_DR);
    assign bsr_mode    = ir_q == IR_EXTEST;
    assign bsr_tdi     = tdi;
    assign chain_sel   = chain_sel_q;
    assign tap_state   = state_q;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed self-checking bench for jtag_tap_ctrl
module tb_jtag_tap_ctrl;
    localparam int          SW  = 2;
    localparam logic [31:0] IDC = 32'h4A7B_2001;

    logic          tck = 1'b0, trst = 1'b1, tms = 1'b1, tdi = 1'b0, bsr_so = 1'b0;
    logic          tdo, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode, bsr_tdi;
    logic [SW-1:0] chain_sel;
    logic [3:0]    tap_state;
    int            pass_cnt = 0, total = 0;
    int            cap_n, sh_n, up_n;

    // Three chains give a 2-bit select so an out-of-range code (3) is expressible.
    jtag_tap_ctrl #(.CHAIN_NUM(3), .IR_WIDTH(4), .IDCODE_VAL(IDC)) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .bsr_so(bsr_so),
        .tdo(tdo), .tdo_en(tdo_en), .chain_sel(chain_sel),
        .bsr_capture(bsr_capture), .bsr_shift(bsr_shift), .bsr_update(bsr_update),
        .bsr_mode(bsr_mode), .bsr_tdi(bsr_tdi), .tap_state(tap_state)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic clk1(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic tally();
        cap_n += int'(bsr_capture);
        sh_n  += int'(bsr_shift);
        up_n  += int'(bsr_update);
    endtask

    task automatic to_tlr();
        for (int i = 0; i < 5; i++) clk1(1'b1, 1'b0);
    endtask

    // From RTI: load an instruction, returning the bits seen on tdo during Shift-IR; ends in RTI.
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        clk1(1'b1, 1'b0); clk1(1'b1, 1'b0); clk1(1'b0, 1'b0); clk1(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = tdo;
            clk1(i == 3, v[i]);
        end
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0);
    endtask

    // From RTI: n-bit DR scan, LSB first, returning tdo bits; ends in RTI.
    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0); clk1(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            clk1(i == n - 1, din[i]);
        end
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        total++; if (tap_state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", tap_state); else pass_cnt++;
        total++; if ({tdo_en, tdo} !== 2'b00) $display("FAIL reset_tdo: got %b expected 00", {tdo_en, tdo}); else pass_cnt++;
        total++; if (chain_sel !== 2'd0) $display("FAIL reset_chain_sel: got %0d expected 0", chain_sel); else pass_cnt++;
        total++; if ({bsr_capture, bsr_shift, bsr_update, bsr_mode} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {bsr_capture, bsr_shift, bsr_update, bsr_mode}); else pass_cnt++;
        trst = 1'b0;
        clk1(1'b0, 1'b0);
        total++; if (tap_state !== 4'd1) $display("FAIL reset_to_rti: got %0d expected 1", tap_state); else pass_cnt++;
    endtask

    task automatic test_idcode();
        logic [31:0] o;
        logic [3:0]  c;
        dr_scan(32, 32'h0, o);
        total++; if (o !== IDC) $display("FAIL idcode_scan: got %h expected %h", o, IDC); else pass_cnt++;
        load_ir(4'h2, c);
        total++; if (c[1:0] !== 2'b01) $display("FAIL ir_capture: got %b expected 01", c[1:0]); else pass_cnt++;
        // IDCODE scan interrupted by Pause, resumed through Exit2 without recapture.
        o = '0;
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0);
        total++; if (bsr_capture !== 1'b0) $display("FAIL idcode_no_capture_strobe: got %b expected 0", bsr_capture); else pass_cnt++;
        clk1(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin o[i] = tdo; clk1(i == 7, 1'b0); end
        clk1(1'b0, 1'b0); clk1(1'b0, 1'b0); clk1(1'b0, 1'b0);
        total++; if ({tap_state, tdo_en} !== {4'd6, 1'b0}) $display("FAIL pause_dr: got %0d/%b expected 6/0", tap_state, tdo_en); else pass_cnt++;
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0);
        for (int i = 8; i < 16; i++) begin o[i] = tdo; clk1(i == 15, 1'b0); end
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0);
        total++; if (o[15:0] !== IDC[15:0]) $display("FAIL pause_resume: got %h expected %h", o[15:0], IDC[15:0]); else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [31:0] o;
        logic [3:0]  c;
        load_ir(4'hF, c);
        total++; if (c !== 4'b0001) $display("FAIL ir_capture_full: got %b expected 0001", c); else pass_cnt++;
        dr_scan(5, 32'b01101, o);
        total++; if (o[4:0] !== 5'b11010) $display("FAIL bypass_delay: got %b expected 11010", o[4:0]); else pass_cnt++;
        load_ir(4'h7, c);
        dr_scan(3, 32'b111, o);
        total++; if (o[2:0] !== 3'b110) $display("FAIL unknown_as_bypass: got %b expected 110", o[2:0]); else pass_cnt++;
    endtask

    task automatic test_chain_sel();
        logic [31:0] o;
        logic [3:0]  c;
        load_ir(4'h3, c);
        dr_scan(SW, 32'd1, o);
        total++; if (o[SW-1:0] !== 2'd0) $display("FAIL csel_capture0: got %0d expected 0", o[SW-1:0]); else pass_cnt++;
        total++; if (chain_sel !== 2'd1) $display("FAIL csel_set1: got %0d expected 1", chain_sel); else pass_cnt++;
        dr_scan(SW, 32'd3, o);
        total++; if (o[SW-1:0] !== 2'd1) $display("FAIL csel_capture1: got %0d expected 1", o[SW-1:0]); else pass_cnt++;
        total++; if (chain_sel !== 2'd1) $display("FAIL csel_out_of_range: got %0d expected 1", chain_sel); else pass_cnt++;
        dr_scan(SW, 32'd2, o);
        total++; if (chain_sel !== 2'd2) $display("FAIL csel_set2: got %0d expected 2", chain_sel); else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] o;
        clk1(1'b1, 1'b0); clk1(1'b0, 1'b0); clk1(1'b0, 1'b0); clk1(1'b0, 1'b1);
        total++; if ({tap_state, tdo_en} !== {4'd4, 1'b1}) $display("FAIL in_shdr: got %0d/%b expected 4/1", tap_state, tdo_en); else pass_cnt++;
        trst = 1'b1;
        #1;
        total++; if ({tap_state, tdo_en, chain_sel} !== {4'd0, 1'b0, 2'd0})
            $display("FAIL async_reset: got %0d/%b/%0d expected 0/0/0", tap_state, tdo_en, chain_sel); else pass_cnt++;
        clk1(1'b0, 1'b1); clk1(1'b0, 1'b1);
        total++; if (tap_state !== 4'd0) $display("FAIL reset_hold: got %0d expected 0", tap_state); else pass_cnt++;
        trst = 1'b0;
        clk1(1'b0, 1'b0);
        dr_scan(32, 32'h0, o);
        total++; if (o !== IDC) $display("FAIL reset_ir_idcode: got %h expected %h", o, IDC); else pass_cnt++;
        total++; if (chain_sel !== 2'd0) $display("FAIL reset_chain_sel_held: got %0d expected 0", chain_sel); else pass_cnt++;
    endtask

    task automatic test_extest();
        logic [3:0] c;
        logic [3:0] pat;
        pat = 4'b1011;
        load_ir(4'h1, c);
        total++; if (bsr_mode !== 1'b0) $display("FAIL sample_mode: got %b expected 0", bsr_mode); else pass_cnt++;
        load_ir(4'h0, c);
        total++; if (bsr_mode !== 1'b1) $display("FAIL extest_mode: got %b expected 1", bsr_mode); else pass_cnt++;
        cap_n = 0; sh_n = 0; up_n = 0;
        clk1(1'b1, 1'b0); tally();
        clk1(1'b0, 1'b0); tally();
        total++; if (bsr_capture !== 1'b1) $display("FAIL capture_in_capdr: got %b expected 1", bsr_capture); else pass_cnt++;
        clk1(1'b0, 1'b0); tally();
        for (int i = 0; i < 4; i++) begin
            bsr_so = pat[i];
            tdi    = ~pat[i];
            #1;
            total++; if ({tdo, bsr_tdi} !== {pat[i], ~pat[i]})
                $display("FAIL extest_tdo_%0d: got %b expected %b", i, {tdo, bsr_tdi}, {pat[i], ~pat[i]}); else pass_cnt++;
            clk1(i == 3, tdi); tally();
        end
        clk1(1'b1, 1'b0); tally();
        total++; if (bsr_update !== 1'b1) $display("FAIL update_in_upddr: got %b expected 1", bsr_update); else pass_cnt++;
        clk1(1'b0, 1'b0); tally();
        total++; if ({cap_n, sh_n, up_n} !== {32'd1, 32'd4, 32'd1})
            $display("FAIL strobe_counts: got cap=%0d sh=%0d up=%0d expected 1/4/1", cap_n, sh_n, up_n); else pass_cnt++;
        total++; if (bsr_mode !== 1'b1) $display("FAIL extest_mode_held: got %b expected 1", bsr_mode); else pass_cnt++;
    endtask

    task automatic test_tlr_all_states();
        logic [5:0]  path [16];
        int          plen [16];
        logic [31:0] o;
        logic [3:0]  c;
        path = '{6'b000111, 6'b0, 6'b1, 6'b01, 6'b001, 6'b101, 6'b0101, 6'b10101,
                 6'b1101, 6'b11, 6'b011, 6'b0011, 6'b1011, 6'b01011, 6'b101011, 6'b11011};
        plen = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
        for (int s = 0; s < 16; s++) begin
            load_ir(4'h0, c);
            for (int k = 0; k < plen[s]; k++) clk1(path[s][k], 1'b0);
            total++; if (tap_state !== 4'(s)) $display("FAIL walk_%0d: got %0d expected %0d", s, tap_state, s); else pass_cnt++;
            to_tlr();
            total++; if ({tap_state, bsr_mode} !== 5'b0000_0)
                $display("FAIL tlr_from_%0d: got %0d/%b expected 0/0", s, tap_state, bsr_mode); else pass_cnt++;
            clk1(1'b0, 1'b0);
            dr_scan(32, 32'h0, o);
            total++; if (o !== IDC) $display("FAIL tlr_ir_%0d: got %h expected %h", s, o, IDC); else pass_cnt++;
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_idcode();
        test_bypass();
        test_chain_sel();
        test_reset_mid_shift();
        test_extest();
        test_tlr_all_states();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
